// File: rtl/dht11_leitor.sv
// dht11_leitor: single-wire DHT11 bus master; one start pulse runs one 40-bit read.
// Optional macro DHT11_CRC_CHECK_EN rejects frames whose checksum does not match.
`timescale 1ns/1ps
module dht11_leitor #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int T_START_US      = 18000,
  parameter int T_TIMEOUT_US    = 200,
  parameter int T_BIT_THRESH_US = 40
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  inout  wire        dht_data,
  output logic [7:0] HUM_INT,
  output logic [7:0] HUM_FLOAT,
  output logic [7:0] TEMP_INT,
  output logic [7:0] TEMP_FLOAT,
  output logic [7:0] CRC,
  output logic       busy,
  output logic       done,
  output logic       erro
);

  localparam int          DIV        = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;
  localparam logic [15:0] PRESC_MAX  = 16'(DIV - 1);
  localparam logic [15:0] T_START_C  = 16'(T_START_US);
  localparam logic [15:0] T_TOUT_C   = 16'(T_TIMEOUT_US);
  localparam logic [15:0] T_THRESH_C = 16'(T_BIT_THRESH_US);

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, FINISH, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] sr_q, sr_d;
  logic [39:0] out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        erro_q, erro_d;
  logic        tick, rise, fall, timeout, crc_ok;

  // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edges
  assign sync_d  = {sync_q[1:0], dht_data};
  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign tick    = (presc_q == PRESC_MAX);
  assign timeout = (us_cnt_q >= T_TOUT_C);

`ifdef DHT11_CRC_CHECK_EN
  logic [7:0] crc_sum;
  assign crc_sum = sr_q[39:32] + sr_q[31:24] + sr_q[23:16] + sr_q[15:8];
  assign crc_ok  = (crc_sum == sr_q[7:0]);
`else
  assign crc_ok  = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    case (state_q)
      IDLE:      if (start) state_d = START_LOW;
      START_LOW: if (us_cnt_q >= T_START_C) state_d = RELEASE;
      RELEASE:   if (fall) state_d = RESP_LOW;  else if (timeout) state_d = ERROR;
      RESP_LOW:  if (rise) state_d = RESP_HIGH; else if (timeout) state_d = ERROR;
      RESP_HIGH: begin
        if (fall) begin
          state_d   = BIT_LOW;
          bit_cnt_d = 6'd0;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      BIT_LOW:   if (rise) state_d = BIT_HIGH; else if (timeout) state_d = ERROR;
      BIT_HIGH: begin
        if (fall) begin
          sr_d      = {sr_q[38:0], (us_cnt_q > T_THRESH_C)};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? FINISH : BIT_LOW;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      FINISH:    state_d = crc_ok ? IDLE : ERROR;
      ERROR:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Phase timer restarts on every state change so each phase is measured alone
  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (state_d != state_q)               us_cnt_d = 16'd0;
    else if (tick && us_cnt_q != 16'hFFFF) us_cnt_d = us_cnt_q + 16'd1;
    else                                   us_cnt_d = us_cnt_q;
    busy_d = (state_d != IDLE);
    done_d = (state_q == FINISH) && crc_ok;
    out_d  = done_d ? sr_q : out_q;
    if (state_q == IDLE && start) erro_d = 1'b0;
    else if (state_q == ERROR)    erro_d = 1'b1;
    else                          erro_d = erro_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync_q    <= 3'b111;
      presc_q   <= 16'd0;
      us_cnt_q  <= 16'd0;
      bit_cnt_q <= 6'd0;
      sr_q      <= 40'd0;
      out_q     <= 40'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      presc_q   <= presc_d;
      us_cnt_q  <= us_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  assign dht_data   = (state_q == START_LOW) ? 1'b0 : 1'bz;
  assign HUM_INT    = out_q[39:32];
  assign HUM_FLOAT  = out_q[31:24];
  assign TEMP_INT   = out_q[23:16];
  assign TEMP_FLOAT = out_q[15:8];
  assign CRC        = out_q[7:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign erro       = erro_q;

endmodule

// File: tb/tb_dht11_leitor.sv
// Testbench for dht11_leitor: behavioural DHT11 sensor, table-driven frames plus corner sequences.
`timescale 1ns/1ps
module tb_dht11_leitor;

  logic       clock = 1'b0;
  logic       reset_n, start, sensor_low;
  wire        dht_data;
  logic [7:0] HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC;
  logic       busy, done, erro;

  int n_pass = 0, n_total = 0;
  int cyc = 0, done_cnt = 0;

  pullup (dht_data);
  assign dht_data = sensor_low ? 1'b0 : 1'bz;

  dht11_leitor #(
    .CLK_FREQ_HZ(1000000), .T_START_US(100), .T_TIMEOUT_US(200), .T_BIT_THRESH_US(40)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dht_data(dht_data),
    .HUM_INT(HUM_INT), .HUM_FLOAT(HUM_FLOAT), .TEMP_INT(TEMP_INT),
    .TEMP_FLOAT(TEMP_FLOAT), .CRC(CRC), .busy(busy), .done(done), .erro(erro)
  );

  always #500 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #80_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [39:0] frame;
    bit          respond;
    int          exp_done;
    int          exp_erro;
    logic [39:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_bytes(input string tag, input logic [39:0] exp);
    chk({tag, "_hum_int"},    32'(HUM_INT),    32'(exp[39:32]));
    chk({tag, "_hum_float"},  32'(HUM_FLOAT),  32'(exp[31:24]));
    chk({tag, "_temp_int"},   32'(TEMP_INT),   32'(exp[23:16]));
    chk({tag, "_temp_float"}, 32'(TEMP_FLOAT), 32'(exp[15:8]));
    chk({tag, "_crc"},        32'(CRC),        32'(exp[7:0]));
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("busy_falls", 32'(busy), 0);
  endtask

  // Sensor model: 80 low, 80 high, then 50 low + 26/70 high per bit, MSB first
  task automatic sensor_send(input logic [39:0] bits, input bit respond,
                             input int stop_bit, input int start_bit);
    int n;
    n = 0;
    while (dht_data !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("host_pulls_low", 32'(dht_data === 1'b0), 1);
    n = 0;
    while (dht_data === 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("host_start_width", 32'(n >= 95 && n <= 106), 1);
    if (!respond) return;
    repeat (20) @(negedge clock);
    sensor_low = 1'b1;
    repeat (80) @(negedge clock);
    sensor_low = 1'b0;
    repeat (80) @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      if (i == stop_bit) begin
        repeat (10) @(negedge clock);
        return;
      end
      if (i == start_bit) begin
        repeat (10) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (39) @(negedge clock);
      end else begin
        repeat (50) @(negedge clock);
      end
      sensor_low = 1'b0;
      repeat (bits[39-i] ? 70 : 26) @(negedge clock);
    end
    sensor_low = 1'b1;
    repeat (50) @(negedge clock);
    sensor_low = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0, t0, n;
    d0 = done_cnt;
    pulse_start();
    t0 = cyc;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    sensor_send(v.frame, v.respond, -1, -1);
    wait_idle(n);
    if (!v.respond) chk({tag, "_timeout_latency"}, 32'((cyc - t0) >= 295 && (cyc - t0) <= 315), 1);
    repeat (5) @(negedge clock);
    chk({tag, "_done_pulses"}, done_cnt - d0, v.exp_done);
    chk({tag, "_erro"}, 32'(erro), v.exp_erro);
    chk({tag, "_line_released"}, 32'(dht_data), 1);
    chk_bytes(tag, v.exp_data);
  endtask

  initial begin
    int d0, n;
    vecs[0] = '{frame: 40'h3700190555, respond: 1'b0, exp_done: 0, exp_erro: 1, exp_data: 40'h0};
    vecs[1] = '{frame: 40'h3700190555, respond: 1'b1, exp_done: 1, exp_erro: 0, exp_data: 40'h3700190555};
`ifdef DHT11_CRC_CHECK_EN
    vecs[2] = '{frame: 40'h3700190556, respond: 1'b1, exp_done: 0, exp_erro: 1, exp_data: 40'h3700190555};
`else
    vecs[2] = '{frame: 40'h3700190556, respond: 1'b1, exp_done: 1, exp_erro: 0, exp_data: 40'h3700190556};
`endif
    vecs[3] = '{frame: 40'hA53C00FFE0, respond: 1'b1, exp_done: 1, exp_erro: 0, exp_data: 40'hA53C00FFE0};

    start = 1'b0;
    sensor_low = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_erro", 32'(erro), 0);
    chk("rst_line", 32'(dht_data), 1);
    chk_bytes("rst", 40'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Second start during bit 10 must be ignored
    d0 = done_cnt;
    pulse_start();
    sensor_send(40'h3700190555, 1'b1, -1, 10);
    wait_idle(n);
    repeat (30) @(negedge clock);
    chk("midstart_done_pulses", done_cnt - d0, 1);
    chk("midstart_busy", 32'(busy), 0);
    chk("midstart_line", 32'(dht_data), 1);
    chk("midstart_erro", 32'(erro), 0);
    chk_bytes("midstart", 40'h3700190555);

    // Reset during bit 20, then a fresh complete read
    d0 = done_cnt;
    pulse_start();
    sensor_send(40'h3700190555, 1'b1, 20, -1);
    chk("bit20_busy", 32'(busy), 1);
    #100 reset_n = 1'b0;
    #1 sensor_low = 1'b0;
    #1;
    chk("bit20_rst_line", 32'(dht_data), 1);
    chk("bit20_rst_busy", 32'(busy), 0);
    chk("bit20_rst_erro", 32'(erro), 0);
    chk_bytes("bit20_rst", 40'h0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("bit20_no_done", done_cnt - d0, 0);
    run_vec(vecs[1], "after_rst");

    // Async reset during START_LOW releases the line at once
    pulse_start();
    repeat (10) @(negedge clock);
    chk("startlow_line_low", 32'(dht_data), 0);
    #200 reset_n = 1'b0;
    #1;
    chk("startlow_rst_line", 32'(dht_data), 1);
    chk("startlow_rst_busy", 32'(busy), 0);
    chk_bytes("startlow_rst", 40'h0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
